l2_bank_scrubber: RTL

Background ECC scrub controller placed between the L2 TCDM interconnect port and one ecc_sram_wrap bank. It shares the bank between the TCDM requester, which always has priority, and an internal scrubber. The scrubber walks every word of the bank, reads it and writes back corrected data when a correctable error is reported. Fix and uncorrectable-error pulses feed the ecc_manager counters.

---
 rtl/l2_bank_scrubber_pkg.sv | 17 +
 rtl/l2_bank_scrubber.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/l2_bank_scrubber_pkg.sv
// Shared types and constants for the L2 bank ECC scrubber.
package l2_scrub_pkg;

    // Scrubber walk: wait out the interval, read, inspect, optionally write back, advance.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CHK  = 3'd2,
        WB   = 3'd3,
        NEXT = 3'd4
    } scrub_state_e;

    // Bit positions inside bank_error_i.
    localparam int unsigned ERR_CORR   = 0;
    localparam int unsigned ERR_UNCORR = 1;

endpackage

// File: rtl/l2_bank_scrubber.sv
// Background ECC scrubber sharing one SRAM bank with the TCDM port.
// TCDM always wins the bank; the scrubber only drives bank_* while tcdm_req_i is low.
//
// Handshake: a bank access (from either side) completes in the cycle where
// bank_req_o && bank_gnt_i; read data/error arrive on the following cycle.
// The TCDM side sees tcdm_gnt_o = bank_gnt_i only while it is requesting.
module l2_bank_scrubber
    import l2_scrub_pkg::*;
#(
    parameter int unsigned  BANK_SIZE = 32768,
    localparam int unsigned AW        = $clog2(BANK_SIZE)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          scrub_en_i,
    input  logic [15:0]   scrub_interval_i,
    input  logic          tcdm_req_i,
    input  logic          tcdm_wen_i,
    input  logic [31:0]   tcdm_add_i,
    input  logic [31:0]   tcdm_wdata_i,
    input  logic [3:0]    tcdm_be_i,
    output logic          tcdm_gnt_o,
    output logic [31:0]   tcdm_rdata_o,
    output logic          bank_req_o,
    output logic          bank_wen_o,
    output logic [31:0]   bank_add_o,
    output logic [31:0]   bank_wdata_o,
    output logic [3:0]    bank_be_o,
    input  logic          bank_gnt_i,
    input  logic [31:0]   bank_rdata_i,
    input  logic [1:0]    bank_error_i,
    output logic          scrub_fix_o,
    output logic          scrub_uncorr_o,
    output logic [AW-1:0] scrub_addr_o
);

    scrub_state_e  state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          abort_q, abort_d;
    logic          fix_q, fix_d;
    logic          uncorr_q, uncorr_d;

    logic [31:0]   scrub_byte_addr;
    logic          tcdm_collide;

    assign scrub_byte_addr = {{(30-AW){1'b0}}, addr_q, 2'b00};

    // A granted TCDM write to the word being scrubbed makes any pending writeback stale.
    assign tcdm_collide = tcdm_req_i && !tcdm_wen_i && bank_gnt_i &&
                          (tcdm_add_i[AW+1:2] == addr_q);

    assign tcdm_rdata_o   = bank_rdata_i;
    assign scrub_fix_o    = fix_q;
    assign scrub_uncorr_o = uncorr_q;
    assign scrub_addr_o   = addr_q;

    // Bank port mux: TCDM passes straight through; otherwise the scrubber may drive.
    always_comb begin
        bank_req_o   = 1'b0;
        bank_wen_o   = 1'b1;
        bank_add_o   = 32'h0;
        bank_wdata_o = 32'h0;
        bank_be_o    = 4'h0;
        tcdm_gnt_o   = 1'b0;
        if (tcdm_req_i) begin
            bank_req_o   = 1'b1;
            bank_wen_o   = tcdm_wen_i;
            bank_add_o   = tcdm_add_i;
            bank_wdata_o = tcdm_wdata_i;
            bank_be_o    = tcdm_be_i;
            tcdm_gnt_o   = bank_gnt_i;
        end else if (state_q == RD) begin
            bank_req_o = 1'b1;
            bank_wen_o = 1'b1;
            bank_add_o = scrub_byte_addr;
            bank_be_o  = 4'hF;
        end else if (state_q == WB && !abort_q) begin
            bank_req_o   = 1'b1;
            bank_wen_o   = 1'b0;
            bank_add_o   = scrub_byte_addr;
            bank_wdata_o = wb_data_q;
            bank_be_o    = 4'hF;
        end
    end

    // Scrub FSM next-state, interval counter, address walk and event pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wb_data_d = wb_data_q;
        abort_d   = abort_q;
        fix_d     = 1'b0;
        uncorr_d  = 1'b0;

        if ((state_q == CHK || state_q == WB) && tcdm_collide) begin
            abort_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (scrub_en_i) begin
                    state_d = RD;
                end
            end
            RD: begin
                if (!tcdm_req_i && bank_gnt_i) begin
                    state_d = CHK;
                end
            end
            CHK: begin
                if (bank_error_i[ERR_UNCORR]) begin
                    uncorr_d = 1'b1;
                    state_d  = NEXT;
                end else if (bank_error_i[ERR_CORR]) begin
                    wb_data_d = bank_rdata_i;
                    state_d   = WB;
                end else begin
                    state_d = NEXT;
                end
            end
            WB: begin
                // Newer TCDM data already sits in the word: drop the writeback.
                if (abort_q || tcdm_collide) begin
                    state_d = NEXT;
                end else if (!tcdm_req_i && bank_gnt_i) begin
                    fix_d   = 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                addr_d  = addr_q + AW'(1);
                cnt_d   = scrub_interval_i;
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            addr_q    <= '0;
            wb_data_q <= 32'h0;
            abort_q   <= 1'b0;
            fix_q     <= 1'b0;
            uncorr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wb_data_q <= wb_data_d;
            abort_q   <= abort_d;
            fix_q     <= fix_d;
            uncorr_q  <= uncorr_d;
        end
    end

endmodule
